// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control unit: opcodes, funct codes, ALUOp and ALUControl.
// Optional jump decode is enabled by defining MIPS_CU_JUMP_EN.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic   reg_write;
    logic   reg_dst;
    logic   alu_src;
    logic   branch;
    logic   mem_write;
    logic   mem_to_reg;
    logic   jump;
    logic   alu_known;
    aluop_t alu_op;
  } main_ctrl_t;

  localparam main_ctrl_t CTRL_NOP = '{
    reg_write: 1'b0, reg_dst: 1'b0, alu_src: 1'b0, branch: 1'b0,
    mem_write: 1'b0, mem_to_reg: 1'b0, jump: 1'b0, alu_known: 1'b0,
    alu_op: ALUOP_ADD
  };

  function automatic main_ctrl_t make_ctrl(
    input logic   reg_write,
    input logic   reg_dst,
    input logic   alu_src,
    input logic   branch,
    input logic   mem_write,
    input logic   mem_to_reg,
    input aluop_t alu_op
  );
    main_ctrl_t c;
    c.reg_write  = reg_write;
    c.reg_dst    = reg_dst;
    c.alu_src    = alu_src;
    c.branch     = branch;
    c.mem_write  = mem_write;
    c.mem_to_reg = mem_to_reg;
    c.jump       = 1'b0;
    c.alu_known  = 1'b1;
    c.alu_op     = alu_op;
    return c;
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and funct to ALUControl, flagging unsupported funct codes.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  // ALUOp/funct to ALU operation select
  always_comb begin
    alu_control = ALU_AND;
    funct_valid = 1'b1;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: begin
            alu_control = ALU_AND;
            funct_valid = 1'b0;
          end
        endcase
      end
      default: begin
        alu_control = ALU_AND;
        funct_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// MIPS main decoder plus registered control outputs (1-cycle latency from op/funct).
// Define MIPS_CU_JUMP_EN to add the registered Jump output and decode of opcode j.
module mips_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       AluSrc,
  output logic       Branch,
  output logic       MemWrite,
  output logic       MemtoReg,
`ifdef MIPS_CU_JUMP_EN
  output logic       Jump,
`endif
  output logic [2:0] ALUControl
);

  main_ctrl_t ctrl;
  logic [2:0] dec_alu_control;
  logic       dec_funct_valid;
  logic [2:0] next_alu_control;
  logic       next_reg_write;

  // Main opcode decode
  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_RTYPE: ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT);
      OP_LW:    ctrl = make_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALUOP_ADD);
      OP_SW:    ctrl = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALUOP_ADD);
      OP_BEQ:   ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_SUB);
      OP_ADDI:  ctrl = make_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD);
`ifdef MIPS_CU_JUMP_EN
      OP_J: begin
        ctrl      = CTRL_NOP;
        ctrl.jump = 1'b1;
      end
`endif
      default:  ctrl = CTRL_NOP;
    endcase
  end

  mips_alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct       (funct),
    .alu_control (dec_alu_control),
    .funct_valid (dec_funct_valid)
  );

  // Unknown opcodes force a NOP ALU select; bad R-type funct suppresses the write
  always_comb begin
    if (ctrl.alu_known) begin
      next_alu_control = dec_alu_control;
    end else begin
      next_alu_control = ALU_AND;
    end
    if (ctrl.alu_op == ALUOP_FUNCT && !dec_funct_valid) begin
      next_reg_write = 1'b0;
    end else begin
      next_reg_write = ctrl.reg_write;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      RegDst     <= 1'b0;
      AluSrc     <= 1'b0;
      Branch     <= 1'b0;
      MemWrite   <= 1'b0;
      MemtoReg   <= 1'b0;
      ALUControl <= 3'b000;
`ifdef MIPS_CU_JUMP_EN
      Jump       <= 1'b0;
`endif
    end else begin
      RegWrite   <= next_reg_write;
      RegDst     <= ctrl.reg_dst;
      AluSrc     <= ctrl.alu_src;
      Branch     <= ctrl.branch;
      MemWrite   <= ctrl.mem_write;
      MemtoReg   <= ctrl.mem_to_reg;
      ALUControl <= next_alu_control;
`ifdef MIPS_CU_JUMP_EN
      Jump       <= ctrl.jump;
`endif
    end
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Self-checking bench for mips_control_unit: directed test plan plus random op/funct against a table model.
module tb_mips_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       RegWrite, RegDst, AluSrc, Branch, MemWrite, MemtoReg;
  logic [2:0] ALUControl;
  logic       jump_obs;
  int         checks;
  int         failures;

`ifdef MIPS_CU_JUMP_EN
  logic Jump;
  assign jump_obs = Jump;
`else
  assign jump_obs = 1'b0;
`endif

  mips_control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .AluSrc     (AluSrc),
    .Branch     (Branch),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
`ifdef MIPS_CU_JUMP_EN
    .Jump       (Jump),
`endif
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {Jump, RegWrite, RegDst, AluSrc, Branch, MemWrite, MemtoReg, ALUControl}
  function automatic logic [9:0] observed();
    return {jump_obs, RegWrite, RegDst, AluSrc, Branch, MemWrite, MemtoReg, ALUControl};
  endfunction

  // Reference: instruction semantics straight from the opcode/funct tables
  function automatic logic [9:0] model(input logic [5:0] o, input logic [5:0] f);
    logic j, rw, rd, as, br, mw, mr;
    logic [2:0] alu;
    {j, rw, rd, as, br, mw, mr} = 7'b0;
    alu = 3'b000;
    case (o)
      6'h00: begin
        rd = 1'b1;
        rw = 1'b1;
        case (f)
          6'h20: alu = 3'b010;
          6'h22: alu = 3'b110;
          6'h24: alu = 3'b000;
          6'h25: alu = 3'b001;
          6'h2a: alu = 3'b111;
          default: begin alu = 3'b000; rw = 1'b0; end
        endcase
      end
      6'h23: begin rw = 1'b1; as = 1'b1; mr = 1'b1; alu = 3'b010; end
      6'h2b: begin as = 1'b1; mw = 1'b1; alu = 3'b010; end
      6'h04: begin br = 1'b1; alu = 3'b110; end
      6'h08: begin rw = 1'b1; as = 1'b1; alu = 3'b010; end
`ifdef MIPS_CU_JUMP_EN
      6'h02: j = 1'b1;
`endif
      default: ;
    endcase
    return {j, rw, rd, as, br, mw, mr, alu};
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply op/funct before an edge and check the registered result just after it
  task automatic step(input logic [5:0] o, input logic [5:0] f, input string tag);
    @(negedge clk);
    op = o;
    funct = f;
    @(posedge clk);
    #1;
    check($sformatf("%s op=%b fn=%b", tag, o, f), observed(), model(o, f));
  endtask

  logic [5:0] op_pool [8];
  logic [5:0] fn_pool [6];

  initial begin
    checks = 0;
    failures = 0;
    op_pool = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h3f, 6'h00};
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};

    // Reset held with lw on the inputs
    rst_n = 1'b0;
    op = 6'h23;
    funct = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", observed(), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_lw", observed(), {1'b0, 6'b101001, 3'b010});

    // R-type sweep
    step(6'h00, 6'h20, "rtype_add");
    step(6'h00, 6'h22, "rtype_sub");
    step(6'h00, 6'h24, "rtype_and");
    step(6'h00, 6'h25, "rtype_or");
    step(6'h00, 6'h2a, "rtype_slt");
    step(6'h2b, 6'h15, "sw");
    step(6'h08, 6'h2a, "addi");
    step(6'h04, 6'h20, "beq");
    step(6'h3f, 6'h20, "illegal_op");
    step(6'h00, 6'h00, "illegal_funct");
    step(6'h02, 6'h00, "jump_opcode");
    check("jump_literal", observed(),
`ifdef MIPS_CU_JUMP_EN
          10'b1000000000
`else
          10'b0
`endif
    );

    // Async reset mid-cycle, away from any edge
    step(6'h23, 6'h00, "pre_async_lw");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", observed(), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(6'h00, 6'h2a, "post_async_slt");

    // Random op/funct biased toward defined encodings
    for (int i = 0; i < 300; i++) begin
      logic [5:0] ro, rf;
      ro = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 7)];
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
      step(ro, rf, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
